instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Fetch stage of the RISC_KGP datapath. Sits directly downstream of the program-counter register: it samples the current PC, issues a request/acknowledge read to instruction memory, and presents the fetched word to decode through a valid/ready handshake. It also tells the next-PC logic when the PC may advance. The unit absorbs variable memory latency, discards responses for flushed requests, and traps misaligned PCs.

## Interface
- IMEM_AW, 10, instruction-memory word-address width; the memory holds 2^IMEM_AW words.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- pc_in  in  32  current PC, byte address, from the program-counter register output.
- pc_advance  out  1  next-PC logic loads PC+4 at this edge when 1; otherwise it recirculates the PC.
- flush  in  1  one-cycle pulse from branch resolution; the PC register loads the target at the same edge.
- imem_req  out  1  read request, level.
- imem_addr  out  IMEM_AW  word address, pc[IMEM_AW+1:2].
- imem_ack  in  1  read complete; meaningful only while imem_req=1.
- imem_rdata  in  32  read data, valid with imem_ack.
- instr  out  32  fetched instruction.
- instr_pc  out  32  PC of instr.
- instr_valid  out  1  instr/instr_pc hold a valid fetch.
- instr_ready  in  1  decode accepts instr this cycle.
- fetch_fault  out  1  instr is a misaligned-PC fault (instr=0).
- fetch_count  out  32  count of accepted instructions.

## Operation
- FSM states: IDLE, BUSY, ADV, DRAIN, FAULT. Reset state is IDLE.
- The output slot is free when !instr_valid || instr_ready.
- IDLE:
  - flush: stay in IDLE.
  - Slot free and pc_in[1:0]==0: latch pc_in into a request register and go to BUSY.
  - Slot free and pc_in[1:0]!=0: go to FAULT and set instr_valid=1, instr=0, instr_pc=pc_in, fetch_fault=1. No memory request is issued.
- BUSY:
  - imem_req=1 and imem_addr is taken from the latched PC; both are held stable until ack.
  - On imem_ack with no flush: set instr<=imem_rdata, instr_pc<=latched PC, instr_valid<=1, fetch_fault<=0, and go to ADV.
  - On flush: go to DRAIN. If imem_ack is also 1 in that cycle, the data is dropped and the next state is IDLE.
- ADV: pc_advance=1 for exactly this cycle, then IDLE. flush in ADV forces pc_advance=0 (flush has priority) and clears instr_valid.
- DRAIN: imem_req stays 1 with an unchanged address. On imem_ack the data is discarded and the next state is IDLE; no output update and no pc_advance.
- FAULT: holds the faulting output until accepted and then stays in FAULT with instr_valid=0. Only flush or reset leaves FAULT; flush goes to IDLE.
- flush in any state clears instr_valid and fetch_fault at that edge. This takes priority over a load in the same cycle.
- An accepted handshake (instr_valid && instr_ready) clears instr_valid unless a new load occurs in the same edge.
- fetch_count increments by 1 on each accepted handshake, including faults, and wraps 0xFFFFFFFF to 0. It does not increment when flush coincides with ready.
- Only one memory request is outstanding at any time.

## Timing
- Reset values: state=IDLE, imem_req=0, imem_addr=0, instr=0, instr_pc=0, instr_valid=0, fetch_fault=0, pc_advance=0, fetch_count=0.
- imem_req and imem_addr are decoded from registered state only and have no combinational path from inputs.
- pc_advance is decoded from state and gated by flush.
- With a zero-wait memory (ack in the first BUSY cycle) and ready held at 1:
  - Cycle N: IDLE. Cycle N+1: BUSY, ack. Cycle N+2: ADV, instr_valid=1. Cycle N+3: IDLE with the new pc_in.
  - Throughput is 1 instruction per 3 cycles; k wait states add k cycles.
- pc_in is sampled only in IDLE. The PC register changes only on pc_advance or flush, so pc_in is stable for the whole fetch.
- If reset is asserted mid-request, imem_req drops immediately (asynchronously). A late ack after reset is ignored because ack is only meaningful while imem_req=1.

## Test plan
- Reset, then pc_in=0x0, zero-wait memory returning 0x12345678, ready=1 -> imem_addr=0, instr=0x12345678 and instr_pc=0x0 one cycle after ack, pc_advance pulses once, fetch_count=1.
- Memory with 3 wait states -> imem_req held 4 cycles with stable imem_addr, exactly one pc_advance per fetch, 6 cycles per instruction.
- ready=0 for 5 cycles after instr_valid -> instr and instr_pc held stable, no new imem_req until the handshake completes.
- flush in the second BUSY cycle, ack two cycles later with 0xDEADBEEF -> DRAIN, data discarded, instr_valid stays 0, no pc_advance; the next fetch uses the new pc_in.
- pc_in=0x6 -> no imem_req, instr_valid=1, fetch_fault=1, instr=0, instr_pc=0x6; the unit stays in FAULT until flush with pc_in=0x8, then resumes fetching.
- Assert reset while imem_req=1 -> all outputs return to reset values immediately; after deassert the unit fetches from pc_in normally. fetch_count preloaded near 0xFFFFFFFF wraps to 0 after one further accept.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage between the PC register and decode.
// It samples pc_in, runs one req/ack read to instruction memory, and holds the
// fetched word in a valid/ready output slot. It tells the next-PC logic when
// the PC may advance, discards responses that belong to flushed requests and
// turns a misaligned PC into a fault word.
module instr_fetch_unit #(
    parameter int IMEM_AW = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc_in,
    output logic               pc_advance,
    input  logic               flush,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               fetch_fault,
    output logic [31:0]        fetch_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BUSY  = 3'd1,
        ADV   = 3'd2,
        DRAIN = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] req_pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] instr_pc_reg;
    logic        valid_reg;
    logic        fault_reg;
    logic [31:0] count_reg;

    logic slot_free;
    logic accept;
    logic latch_pc;
    logic load_fetch;
    logic load_fault;

    // A new word may enter the slot when it is empty or being consumed now.
    assign slot_free = !valid_reg || instr_ready;
    assign accept    = valid_reg && instr_ready;

    // State register; reset lands in IDLE with no request outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and the one-cycle load strobes for the datapath.
    always_comb begin
        state_next = state_reg;
        latch_pc   = 1'b0;
        load_fetch = 1'b0;
        load_fault = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!flush && slot_free) begin
                    if (pc_in[1:0] == 2'b00) begin
                        latch_pc   = 1'b1;
                        state_next = BUSY;
                    end else begin
                        load_fault = 1'b1;
                        state_next = FAULT;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    // An ack in the flush cycle retires the request right away.
                    state_next = imem_ack ? IDLE : DRAIN;
                end else if (imem_ack) begin
                    load_fetch = 1'b1;
                    state_next = ADV;
                end
            end
            ADV: begin
                state_next = IDLE;
            end
            DRAIN: begin
                // The stale response is swallowed; only then can a new request go out.
                if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            FAULT: begin
                if (flush) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request address holds the PC sampled in IDLE for the whole transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_pc_reg <= 32'd0;
        end else if (latch_pc) begin
            req_pc_reg <= pc_in;
        end
    end

    // Output slot: flush wins, then a new load, then a plain handshake drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_reg    <= 32'd0;
            instr_pc_reg <= 32'd0;
            valid_reg    <= 1'b0;
            fault_reg    <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
            fault_reg <= 1'b0;
        end else if (load_fetch) begin
            instr_reg    <= imem_rdata;
            instr_pc_reg <= req_pc_reg;
            valid_reg    <= 1'b1;
            fault_reg    <= 1'b0;
        end else if (load_fault) begin
            instr_reg    <= 32'd0;
            instr_pc_reg <= pc_in;
            valid_reg    <= 1'b1;
            fault_reg    <= 1'b1;
        end else if (accept) begin
            valid_reg <= 1'b0;
        end
    end

    // Accepted-instruction counter; a handshake coinciding with flush is void.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= 32'd0;
        end else if (accept && !flush) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    // Memory-side outputs come from registered state only.
    assign imem_req   = (state_reg == BUSY) || (state_reg == DRAIN);
    assign imem_addr  = req_pc_reg[IMEM_AW+1:2];
    assign pc_advance = (state_reg == ADV) && !flush;

    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = valid_reg;
    assign fetch_fault = fault_reg;
    assign fetch_count = count_reg;

endmodule
